// File: rtl/decode_stage_if.sv
// Handshake and decoded-field bundle between fetch, decode_stage and register-read.
// The master side feeds instructions and accepts decoded entries; the slave side
// is the decode stage itself.
interface decode_stage_if #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 32
);
    // Upstream (fetch -> decode)
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_inst;
    logic [PC_W-1:0]   in_pc;

    // Downstream (decode -> register-read)
    logic              out_valid;
    logic              out_ready;
    logic [PC_W-1:0]   out_pc;
    logic [5:0]        out_opcode;
    logic [4:0]        out_rd;
    logic [4:0]        out_rs;
    logic [4:0]        out_rt;
    logic [4:0]        out_shamt;
    logic [5:0]        out_funct;
    logic [DATA_W-1:0] out_imm_sext;
    logic [DATA_W-1:0] out_imm_zext;
    logic [25:0]       out_addr;
    logic [PC_W-1:0]   out_jtarget;
    logic [1:0]        out_opetype;
    logic              out_illegal;

    modport master (
        output in_valid, in_inst, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_opcode, out_rd, out_rs, out_rt,
               out_shamt, out_funct, out_imm_sext, out_imm_zext, out_addr,
               out_jtarget, out_opetype, out_illegal
    );

    modport slave (
        input  in_valid, in_inst, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_opcode, out_rd, out_rs, out_rt,
               out_shamt, out_funct, out_imm_sext, out_imm_zext, out_addr,
               out_jtarget, out_opetype, out_illegal
    );
endinterface

// File: rtl/decode_stage.sv
// Registered instruction-decode stage with a 2-entry skid buffer.
// Each instruction is decoded combinationally on entry and the decoded record is
// stored in a main register (driving the outputs) or a skid register when the
// main register is stalled. in_ready is registered as !skid_valid.
// Optional build macro DECODE_ILLEGAL_EN: flags opcodes outside the supported
// set with out_illegal = 1 and out_opetype = 2'b11.
module decode_stage #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           flush,
    decode_stage_if.slave  bus
);

    typedef enum logic [1:0] {
        OPE_R   = 2'b00,
        OPE_I   = 2'b01,
        OPE_J   = 2'b10,
        OPE_ILL = 2'b11
    } ope_e;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [5:0]        opcode;
        logic [4:0]        rd;
        logic [4:0]        rs;
        logic [4:0]        rt;
        logic [4:0]        shamt;
        logic [5:0]        funct;
        logic [DATA_W-1:0] imm_sext;
        logic [DATA_W-1:0] imm_zext;
        logic [25:0]       addr;
        logic [PC_W-1:0]   jtarget;
        ope_e              opetype;
        logic              illegal;
    } dec_t;

    dec_t            dec_in;
    dec_t            main_q, main_d;
    dec_t            skid_q, skid_d;
    logic            main_valid_q, main_valid_d;
    logic            skid_valid_q, skid_valid_d;
    logic            in_ready_q, in_ready_d;
    logic            in_fire, out_fire;
    logic [PC_W-1:0] pc_plus4;
    logic [31:0]     pc4_ext;
    logic [31:0]     jt_full;

    // Combinational decode of the incoming instruction word.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        dec_in   = '0;
        pc_plus4 = bus.in_pc + PC_W'(4);
        pc4_ext  = 32'(pc_plus4);
        // Region bits come from pc+4 only where PC_W reaches them; zero-extension handles PC_W <= 28.
        jt_full  = (pc4_ext & 32'hF000_0000) | {4'b0000, bus.in_inst[25:0], 2'b00};

        dec_in.pc       = bus.in_pc;
        dec_in.opcode   = bus.in_inst[31:26];
        dec_in.rd       = bus.in_inst[25:21];
        dec_in.rs       = bus.in_inst[20:16];
        dec_in.rt       = bus.in_inst[15:11];
        dec_in.shamt    = bus.in_inst[10:6];
        dec_in.funct    = bus.in_inst[5:0];
        dec_in.imm_sext = {{(DATA_W-16){bus.in_inst[15]}}, bus.in_inst[15:0]};
        dec_in.imm_zext = {{(DATA_W-16){1'b0}}, bus.in_inst[15:0]};
        dec_in.addr     = bus.in_inst[25:0];
        dec_in.jtarget  = jt_full[PC_W-1:0];

        case (bus.in_inst[31:26])
            6'h00:        dec_in.opetype = OPE_R;
            6'h02, 6'h03: dec_in.opetype = OPE_J;
            default:      dec_in.opetype = OPE_I;
        endcase

`ifdef DECODE_ILLEGAL_EN
        case (bus.in_inst[31:26])
            6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08,
            6'h09, 6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h2B: dec_in.illegal = 1'b0;
            default: begin
                dec_in.illegal = 1'b1;
                dec_in.opetype = OPE_ILL;
            end
        endcase
`else
        dec_in.illegal = 1'b0;
`endif
    end

    // Skid-buffer next state: fill main first, spill to skid when main stalls.
    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        in_fire      = bus.in_valid && in_ready_q && !flush;
        out_fire     = main_valid_q && bus.out_ready;

        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!main_valid_q || out_fire) begin
            // in_ready_q == !skid_valid_q, so a full skid never coincides with an accept.
            if (skid_valid_q) begin
                main_d       = skid_q;
                main_valid_d = 1'b1;
                skid_valid_d = 1'b0;
            end else if (in_fire) begin
                main_d       = dec_in;
                main_valid_d = 1'b1;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (in_fire) begin
            skid_d       = dec_in;
            skid_valid_d = 1'b1;
        end

        in_ready_d = !skid_valid_d;
    end

    // Main register, valid flags and registered in_ready, synchronously reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            main_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b0;
        end else begin
            main_q       <= main_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
        end
    end

    // Skid data register; its contents only matter while skid_valid_q is set.
    always_ff @(posedge clk) begin
        // NOTE: data qualified by a valid flag needs no reset; only the flag is cleared.
        skid_q <= skid_d;
    end

    assign bus.in_ready     = in_ready_q;
    assign bus.out_valid    = main_valid_q;
    assign bus.out_pc       = main_q.pc;
    assign bus.out_opcode   = main_q.opcode;
    assign bus.out_rd       = main_q.rd;
    assign bus.out_rs       = main_q.rs;
    assign bus.out_rt       = main_q.rt;
    assign bus.out_shamt    = main_q.shamt;
    assign bus.out_funct    = main_q.funct;
    assign bus.out_imm_sext = main_q.imm_sext;
    assign bus.out_imm_zext = main_q.imm_zext;
    assign bus.out_addr     = main_q.addr;
    assign bus.out_jtarget  = main_q.jtarget;
    assign bus.out_opetype  = main_q.opetype;
    assign bus.out_illegal  = main_q.illegal;

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered, handshaked instruction-decode stage for the 32-bit core.
- Splits each fetched instruction into its fields, classifies the format, computes sign- and zero-extended immediates and the absolute jump target, and carries the PC alongside.
- Sits between fetch and register-read.
- Uses a 2-entry skid buffer so `in_ready` is a registered signal and the stage sustains one instruction per cycle.

Parameters:
- DATA_W, 32, width of the extended-immediate outputs (≥16).
- PC_W, 32, width of the PC and jump target (8..32).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  discard all buffered instructions
- in_valid  in  1  upstream instruction valid
- in_ready  out  1  stage can accept
- in_inst  in  32  instruction word
- in_pc  in  PC_W  byte address of in_inst
- out_valid  out  1  decoded entry valid
- out_ready  in  1  downstream accepts
- out_pc  out  PC_W  PC of entry
- out_opcode  out  6  inst[31:26]
- out_rd  out  5  inst[25:21]
- out_rs  out  5  inst[20:16]
- out_rt  out  5  inst[15:11]
- out_shamt  out  5  inst[10:6]
- out_funct  out  6  inst[5:0]
- out_imm_sext  out  DATA_W  inst[15:0] sign-extended
- out_imm_zext  out  DATA_W  inst[15:0] zero-extended
- out_addr  out  26  inst[25:0]
- out_jtarget  out  PC_W  jump target
- out_opetype  out  2  format class
- out_illegal  out  1  unknown opcode

Behaviour:
- Reset: one clock, reset synchronous and active-high.
  - Both buffer entries are invalidated.
  - `out_valid` = 0, all `out_*` data = 0, `in_ready` = 0 while `rst` is high.
  - `in_ready` = 1 on the first cycle after `rst` falls.
- Handshakes:
  - Input transfer when `in_valid && in_ready` at a rising edge.
  - Output transfer when `out_valid && out_ready`.
- Latency and throughput:
  - An instruction accepted at edge N appears on the outputs after edge N (visible in cycle N+1).
  - Back-to-back throughput is 1 per cycle while `out_ready` = 1.
- Storage: main register (drives outputs) plus skid register. Decode is done combinationally on `in_inst` before storage; the decoded fields are registered.
- Buffer transitions:
  - Main empty → accept goes to main.
  - Main full and draining → accept goes to main.
  - Main full and stalled → accept goes to skid.
  - Main drains while skid full → skid moves to main.
- `in_ready` = !skid_valid, registered.
- Order: strictly FIFO. No reordering or duplication.
- Output stability: while `out_valid && !out_ready`, every `out_*` is held stable.
- Format classification (`out_opetype`):
  - opcode 000000 → 00 (R)
  - 000010 or 000011 → 10 (J)
  - all others → 01 (I)
- Immediates:
  - `out_imm_sext` = {(DATA_W-16){inst[15]}, inst[15:0]}.
  - `out_imm_zext` = {(DATA_W-16){0}, inst[15:0]}.
- Jump target: `out_jtarget` = ({(pc+4)[31:28], addr, 2'b00}) truncated to PC_W. For PC_W ≤ 28, the upper bits come from the {addr, 00} part only. pc+4 wraps modulo 2^PC_W.
- Flush:
  - Flush at edge N clears both entries: `out_valid` = 0 and `in_ready` = 1 after edge N.
  - An input offered in the same cycle as flush is dropped.
  - An output handshake in the same cycle still completes.
- Reset overrides flush.
- Reset mid-stall discards all entries.

Optional Feature:
- Macro: DECODE_ILLEGAL_EN.
- Defined:
  - Legal opcodes: 00, 02, 03, 04, 05, 08, 09, 0C, 0D, 0F, 23, 2B (hex).
  - Any other opcode sets `out_illegal` = 1 and `out_opetype` = 11.
  - The remaining fields decode normally.
- Undefined:
  - `out_illegal` is tied 0.
  - `out_opetype` never takes the value 11.

Test Plan:
- Reset then single accept:
  - Stimulus: after reset, in_inst=32'h012A4020 (R: opcode 0, rd=9, rs=10, rt=8, shamt=0, funct=0x20), pc=0x100, out_ready=1.
  - Response: next cycle out_valid=1, out_opetype=00, out_rd=9, out_rs=10, out_rt=8, out_funct=0x20, out_pc=0x100.
- Immediate extension:
  - Stimulus: in_inst=32'h2128FFFC.
  - Response: out_imm_sext=32'hFFFFFFFC, out_imm_zext=32'h0000FFFC, out_opetype=01.
- Jump target:
  - Stimulus: in_inst=32'h0C000040, pc=32'h40000010.
  - Response: out_opetype=10, out_addr=26'h40, out_jtarget=32'h40000100.
- Backpressure:
  - Stimulus: stream pc=0,4,8,12 with out_ready=0 from cycle 1.
  - Response:
    - Outputs hold pc=0.
    - pc=4 goes to skid, then in_ready=0.
    - After out_ready=1, outputs show pc=0,4,8,12 in order with no loss or duplication.
- Flush with skid full:
  - Stimulus: fill both entries, assert flush together with a new in_valid.
  - Response: next cycle out_valid=0, in_ready=1. The new instruction never appears on the outputs.
- Illegal opcode (DECODE_ILLEGAL_EN defined):
  - Stimulus: in_inst=32'hFC000000.
  - Response: out_illegal=1, out_opetype=11.
  - Same stimulus without the macro: out_illegal=0, out_opetype=01.
